// File: rtl/periph_reg_arbiter.sv
// periph_reg_arbiter: round-robin arbiter sharing one reg bus.
// Optional hung-slave abort: define PERIPH_ARB_TIMEOUT_EN.
package reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module periph_reg_arbiter
    import reg_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  reg_req_t                   in_req_i [NUM_REQ],
    output reg_rsp_t                   in_rsp_o [NUM_REQ],
    output reg_req_t                   out_req_o,
    input  reg_rsp_t                   out_rsp_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       timeout_err_o
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] pick, grant_nxt;
    logic          found;

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] count_q, count_d;
    logic          timeout;
`endif

    assign grant_nxt = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // First valid requester scanning from rr_q upward, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = rr_q;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && in_req_i[IW'(idx)].valid) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Next state, pointer update and bus steering.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        out_req_o = '0;
        for (int i = 0; i < NUM_REQ; i++) in_rsp_o[i] = '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
        count_d = count_q;
        timeout = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
`ifdef PERIPH_ARB_TIMEOUT_EN
                    count_d = '0;
`endif
                end
            end
            BUSY: begin
                out_req_o         = in_req_i[grant_q];
                in_rsp_o[grant_q] = out_rsp_i;
`ifdef PERIPH_ARB_TIMEOUT_EN
                count_d = count_q + 1'b1;
`endif
                if (!in_req_i[grant_q].valid) begin
                    // master walked away: no response, keep rotation
                    state_d = IDLE;
                end else if (out_rsp_i.ready) begin
                    state_d = IDLE;
                    rr_d    = grant_nxt;
`ifdef PERIPH_ARB_TIMEOUT_EN
                end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout                 = 1'b1;
                    out_req_o.valid         = 1'b0;
                    in_rsp_o[grant_q].rdata = 32'hBADC_AB1E;
                    in_rsp_o[grant_q].error = 1'b1;
                    in_rsp_o[grant_q].ready = 1'b1;
                    state_d                 = IDLE;
                    rr_d                    = grant_nxt;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, rotation pointer and grant registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
`ifdef PERIPH_ARB_TIMEOUT_EN
            count_q <= count_d;
`endif
        end
    end

    assign busy_o      = (state_q == BUSY);
    assign grant_idx_o = grant_q;

`ifdef PERIPH_ARB_TIMEOUT_EN
    assign timeout_err_o = timeout;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule
